// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one non-lookahead FIFO write port among
//   NUM_REQ producers using valid/ready handshakes. A winner holds the port
//   for a burst of up to MAX_BURST words. The arbiter then returns to IDLE
//   for one arbitration cycle and resumes the search after the last winner.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req_valid  per-producer word valid
//   req_data   producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-producer accept, one-hot or zero
//   fifo_full  FIFO full flag
//   fifo_wr    FIFO write strobe
//   fifo_din   FIFO write data, zero when not writing
//   fifo_src   ID of the producer owning the port (the writer when fifo_wr=1)
//   busy       high while a burst grant is active
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [ID_W-1:0]               fifo_src,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           st, st_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;

  logic            pick_found;
  logic [ID_W-1:0] pick;
  logic [ID_W:0]   cand;

  // Split the flat data bus into one word per producer.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign g_valid = req_valid[grant];
  assign g_data  = data_arr[grant];

  // Round-robin search: walk rr_ptr, rr_ptr+1, ... and wrap at NUM_REQ.
  // The wrap is explicit so a non-power-of-two NUM_REQ never visits an
  // unused ID.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_EXT) begin
        cand = cand - NUM_REQ_EXT;
      end
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[ID_W-1:0];
      end
    end
  end

  // State register. Reset abandons any in-flight grant and restarts the
  // search from producer 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      st        <= st_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  // Next state and outputs. Outputs are gated by rst so that nothing is
  // written in the reset cycle, even if the registers still hold BURST.
  // The FIFO write path is combinational from the winner's valid/full.
  always_comb begin
    st_nxt    = st;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    cnt_nxt   = burst_cnt;
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    fifo_src  = '0;
    busy      = 1'b0;

    if (!rst) begin
      case (st)
        IDLE: begin
          if (pick_found) begin
            st_nxt    = BURST;
            grant_nxt = pick;
            cnt_nxt   = '0;
          end
        end

        BURST: begin
          busy             = 1'b1;
          fifo_src         = grant;
          req_ready[grant] = !fifo_full;
          fifo_wr          = g_valid && !fifo_full;
          if (fifo_wr) begin
            fifo_din = g_data;
          end
          // A drained producer or a final burst word releases the port.
          // A full stall with valid held keeps the grant and freezes the count.
          if (!g_valid || (fifo_wr && (burst_cnt == LAST_CNT))) begin
            st_nxt  = IDLE;
            rr_nxt  = (grant == LAST_ID) ? '0 : grant + 1'b1;
            cnt_nxt = '0;
          end else if (fifo_wr) begin
            cnt_nxt = burst_cnt + 1'b1;
          end
        end

        default: begin
          st_nxt = IDLE;
        end
      endcase
    end
  end

endmodule
